// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer for an instruction ROM.
// IDLE/RUN/DONE control with stall, halt and branch redirect.
module fetch_ctrl #(
  parameter int D    = 12,
  parameter int OFFW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic            branch_abs,
  input  logic [D-1:0]    target,
  input  logic [OFFW-1:0] offset,
  input  logic            halt,
  output logic [D-1:0]    prog_ctr,
  output logic            running,
  output logic            ack,
  output logic [15:0]     cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [D-1:0] pc_d;
  logic [15:0]  cnt_d;
  logic [D-1:0] off_ext;
  logic [D-1:0] pc_inc;
  logic [D-1:0] pc_rel;
  logic [15:0]  cnt_inc;

  // offset is two's complement; the size cast sign-extends it
  assign off_ext = D'($signed(offset));
  assign pc_inc  = prog_ctr + 1'b1;
  assign pc_rel  = prog_ctr + off_ext;
  assign cnt_inc = (cycle_cnt == 16'hFFFF) ? cycle_cnt
                                           : cycle_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      prog_ctr  <= '0;
      cycle_cnt <= '0;
    end else begin
      state_q   <= state_d;
      prog_ctr  <= pc_d;
      cycle_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = prog_ctr;
    cnt_d   = cycle_cnt;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (stall) begin
          pc_d = prog_ctr;
        end else if (halt) begin
          state_d = DONE;
        end else if (branch_taken) begin
          pc_d = branch_abs ? target : pc_rel;
        end else begin
          pc_d = pc_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign running = (state_q == RUN);
  assign ack     = (state_q == DONE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Inputs change #1 after a rising edge; outputs are checked there too.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        stall;
  logic        branch_taken;
  logic        branch_abs;
  logic [11:0] target;
  logic [7:0]  offset;
  logic        halt;
  logic [11:0] prog_ctr;
  logic        running;
  logic        ack;
  logic [15:0] cycle_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.D(12), .OFFW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_abs   (branch_abs),
    .target       (target),
    .offset       (offset),
    .halt         (halt),
    .prog_ctr     (prog_ctr),
    .running      (running),
    .ack          (ack),
    .cycle_cnt    (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag,
                        input logic [11:0] pc,
                        input logic        run,
                        input logic        ak,
                        input logic [15:0] cnt);
    chk({tag, "_pc"},  {20'd0, prog_ctr}, {20'd0, pc});
    chk({tag, "_run"}, {31'd0, running},  {31'd0, run});
    chk({tag, "_ack"}, {31'd0, ack},      {31'd0, ak});
    chk({tag, "_cnt"}, {16'd0, cycle_cnt}, {16'd0, cnt});
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; stall = 1'b0;
    branch_taken = 1'b0; branch_abs = 1'b0;
    target = '0; offset = '0; halt = 1'b0;
    step();
    step();
    chk_st("reset", 12'h000, 1'b0, 1'b0, 16'd0);

    reset = 1'b0;
    halt = 1'b1; stall = 1'b1; branch_taken = 1'b1;
    step();
    chk_st("idle_hold", 12'h000, 1'b0, 1'b0, 16'd0);
    halt = 1'b0; stall = 1'b0; branch_taken = 1'b0;

    req = 1'b1;
    step();
    req = 1'b0;
    chk_st("start", 12'h000, 1'b1, 1'b0, 16'd0);
    step();
    chk_st("inc1", 12'h001, 1'b1, 1'b0, 16'd1);
    step();
    chk_st("inc2", 12'h002, 1'b1, 1'b0, 16'd2);
    step();
    chk_st("inc3", 12'h003, 1'b1, 1'b0, 16'd3);
    step();
    step();
    chk_st("pc5", 12'h005, 1'b1, 1'b0, 16'd5);

    branch_taken = 1'b1; branch_abs = 1'b0; offset = 8'hFD;
    step();
    chk_st("rel_neg", 12'h002, 1'b1, 1'b0, 16'd6);
    branch_abs = 1'b1; target = 12'h0A0;
    step();
    chk_st("abs_0a0", 12'h0A0, 1'b1, 1'b0, 16'd7);
    target = 12'hFFF;
    step();
    chk_st("abs_fff", 12'hFFF, 1'b1, 1'b0, 16'd8);
    branch_taken = 1'b0;
    step();
    chk_st("wrap_inc", 12'h000, 1'b1, 1'b0, 16'd9);
    branch_taken = 1'b1; target = 12'hFFE;
    step();
    chk_st("abs_ffe", 12'hFFE, 1'b1, 1'b0, 16'd10);
    branch_abs = 1'b0; offset = 8'h04;
    step();
    chk_st("rel_wrap", 12'h002, 1'b1, 1'b0, 16'd11);

    branch_abs = 1'b1; target = 12'h007;
    step();
    chk_st("abs_7", 12'h007, 1'b1, 1'b0, 16'd12);
    stall = 1'b1; halt = 1'b1; target = 12'h055;
    step();
    chk_st("stall1", 12'h007, 1'b1, 1'b0, 16'd13);
    step();
    chk_st("stall2", 12'h007, 1'b1, 1'b0, 16'd14);
    step();
    chk_st("stall3", 12'h007, 1'b1, 1'b0, 16'd15);
    stall = 1'b0; halt = 1'b0;

    target = 12'h010;
    step();
    branch_taken = 1'b0;
    chk_st("abs_010", 12'h010, 1'b1, 1'b0, 16'd16);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk_st("done", 12'h010, 1'b0, 1'b1, 16'd17);
    req = 1'b1;
    step();
    req = 1'b0;
    chk_st("post_done", 12'h010, 1'b0, 1'b0, 16'd17);
    step();
    chk_st("no_restart", 12'h010, 1'b0, 1'b0, 16'd17);

    req = 1'b1;
    step();
    req = 1'b0;
    chk_st("restart", 12'h000, 1'b1, 1'b0, 16'd0);
    branch_taken = 1'b1; branch_abs = 1'b1; target = 12'h123;
    step();
    branch_taken = 1'b0;
    chk_st("abs_123", 12'h123, 1'b1, 1'b0, 16'd1);
    reset = 1'b1; req = 1'b1; halt = 1'b1;
    step();
    reset = 1'b0; req = 1'b0; halt = 1'b0;
    chk_st("run_reset", 12'h000, 1'b0, 1'b0, 16'd0);
    step();
    chk_st("after_reset", 12'h000, 1'b0, 1'b0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter D, default 12, program-counter width matching the instruction ROM address width.
REQ-002 The block SHALL have parameter OFFW, default 8, signed relative-branch offset width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port req  in  1  start-program request.
REQ-006 The block SHALL have port stall  in  1  hold the current instruction (multi-cycle op).
REQ-007 The block SHALL have port branch_taken  in  1  redirect fetch this cycle.
REQ-008 The block SHALL have port branch_abs  in  1  1 = absolute target, 0 = relative offset.
REQ-009 The block SHALL have port target  in  D  absolute branch address.
REQ-010 The block SHALL have port offset  in  OFFW  two's-complement relative offset.
REQ-011 The block SHALL have port halt  in  1  decoded halt at current prog_ctr.
REQ-012 The block SHALL have port prog_ctr  out  D  ROM address pointer, registered.
REQ-013 The block SHALL have port running  out  1  high while in RUN.
REQ-014 The block SHALL have port ack  out  1  one-cycle program-complete pulse.
REQ-015 The block SHALL have port cycle_cnt  out  16  RUN-cycle counter, registered.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 In IDLE with req=1, the block SHALL go to RUN next cycle, load prog_ctr=0 and cycle_cnt=0; with req=0 it SHALL hold all registers.
REQ-018 In RUN, next-cycle priority SHALL be: stall > halt > branch_taken > increment.
REQ-019 With stall=1 in RUN, prog_ctr SHALL hold and the block SHALL stay in RUN; halt and branch_taken SHALL be ignored that cycle.
REQ-020 With halt=1 and stall=0 in RUN, the block SHALL go to DONE and prog_ctr SHALL hold.
REQ-021 With branch_taken=1 and branch_abs=1, next prog_ctr SHALL equal target.
REQ-022 With branch_taken=1 and branch_abs=0, next prog_ctr SHALL equal (prog_ctr + sign-extended offset) mod 2^D, relative to the branch instruction's own address.
REQ-023 Otherwise, next prog_ctr SHALL equal (prog_ctr + 1) mod 2^D; 2^D-1 SHALL wrap to 0.
REQ-024 cycle_cnt SHALL increment on every RUN cycle, including stall cycles and the halt cycle, and SHALL saturate at 16'hFFFF.
REQ-025 running SHALL equal (state==RUN); ack SHALL equal (state==DONE); both SHALL be decoded from the state register only.
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE; prog_ctr and cycle_cnt SHALL hold until the next accepted req.
REQ-027 req SHALL be ignored in RUN and DONE; only a req sampled in IDLE starts a program.
REQ-028 stall, branch_taken and halt SHALL be ignored outside RUN.

Reset
REQ-029 With reset=1 at a rising edge, the block SHALL enter IDLE with prog_ctr=0, cycle_cnt=0, running=0, ack=0, regardless of state or other inputs.
REQ-030 Reset SHALL take priority over req, halt, stall and branch_taken in the same cycle.

Verification
REQ-031 Reset, then 1-cycle req -> running=1 next cycle; prog_ctr 0,1,2,3 on successive cycles; ack=0.
REQ-032 At prog_ctr=5: branch_taken=1, branch_abs=0, offset=8'hFD -> prog_ctr=2 next cycle; then branch_abs=1, target=12'h0A0 -> prog_ctr=12'h0A0.
REQ-033 Absolute jump to 12'hFFF, then no branch -> prog_ctr=12'h000; from 12'hFFE, relative offset=8'h04 -> prog_ctr=12'h002.
REQ-034 At prog_ctr=7: stall=1 for 3 cycles with halt=1 and branch_taken=1 -> prog_ctr stays 7, running stays 1, ack=0, cycle_cnt +3.
REQ-035 Halt at prog_ctr=12'h010 -> DONE with ack=1 for exactly one cycle, then IDLE; prog_ctr stays 12'h010; req during DONE does not restart.
REQ-036 In RUN at prog_ctr=12'h123, reset=1 with req=1 -> next cycle IDLE, prog_ctr=0, cycle_cnt=0, running=0, ack=0.
